lut_neuron_prog: RTL and testbench

- Parametrised, runtime-programmable successor to the fixed combinational LUT neuron: FANIN inputs of IN_BITS each form a truth-table address; the table returns an OUT_BITS activation.
- Table is writable through a config port, and a hardware clear sweep zeroes it.
- Lookups use a registered valid/ready stream, so neurons chain into pipelined layers without regenerating RTL per trained model.

---
 rtl/lut_neuron_pkg.sv | 28 ++
 rtl/lut_neuron_table.sv | 41 ++++
 rtl/lut_neuron_prog.sv | 118 +++++++++++
 tb/tb_lut_neuron_prog.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_neuron_pkg.sv
// Shared types and helpers for the programmable LUT neuron.
// Covers the FSM state enum, address-width arithmetic and input-channel packing.
package lut_neuron_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int MAX_ADDR_W = 32;

  function automatic int addrWidth(input int fanin, input int inBits);
    return fanin * inBits;
  endfunction

  // Replaces channel idx of a packed input word with value (only the low inBits of value are used).
  function automatic logic [MAX_ADDR_W-1:0] packChannel(
    input logic [MAX_ADDR_W-1:0] word,
    input int                    idx,
    input int                    inBits,
    input logic [MAX_ADDR_W-1:0] value
  );
    logic [MAX_ADDR_W-1:0] mask;
    mask = ((MAX_ADDR_W'(1) << inBits) - MAX_ADDR_W'(1)) << (idx * inBits);
    return (word & ~mask) | ((value << (idx * inBits)) & mask);
  endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// Truth-table storage with asynchronous read and a single synchronous write port.
// The write port is shared between the clear sweep and the config interface; the sweep has priority.
module lut_neuron_table
  import lut_neuron_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                i_sweep,
  input  logic [ADDR_W-1:0]   i_sweepAddr,
  input  logic                i_cfgWe,
  input  logic [ADDR_W-1:0]   i_cfgAddr,
  input  logic [OUT_BITS-1:0] i_cfgData,
  input  logic [ADDR_W-1:0]   i_rdAddr,
  output logic [OUT_BITS-1:0] o_rdData
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [OUT_BITS-1:0] r_mem [0:DEPTH-1];

  logic                w_we;
  logic [ADDR_W-1:0]   w_wAddr;
  logic [OUT_BITS-1:0] w_wData;

  assign w_we    = i_sweep | i_cfgWe;
  assign w_wAddr = i_sweep ? i_sweepAddr : i_cfgAddr;
  assign w_wData = i_sweep ? '0 : i_cfgData;

  // Not reset: contents are only trustworthy after a completed sweep.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wAddr] <= w_wData;
    end
  end

  // The read returns pre-edge contents, so a same-cycle lookup and write to one address yields the old value.
  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/lut_neuron_prog.sv
// Runtime-programmable LUT neuron: FANIN packed inputs address a writable truth table.
// A clear sweep zeroes the table after reset or on request; results leave through a registered valid/ready stage.
module lut_neuron_prog
  import lut_neuron_pkg::*;
#(
  parameter int FANIN    = 4,
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 2,
  parameter int CNT_W    = 16,
  localparam int ADDR_W  = addrWidth(FANIN, IN_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_clr,
  output logic                cfg_busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic [CNT_W-1:0]    lookup_cnt
);

  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clrPtr;
  logic                r_busy;
  logic                r_outValid;
  logic [OUT_BITS-1:0] r_outData;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_sweep;
  logic                w_cfgWe;
  logic                w_inReady;
  logic                w_accept;
  logic [OUT_BITS-1:0] w_rdData;

  assign w_sweep   = (r_state == ST_CLEAR);
  assign w_cfgWe   = cfg_we & ~w_sweep;
  assign w_inReady = (r_state == ST_RUN) & (~r_outValid | out_ready);
  assign w_accept  = in_valid & w_inReady;

  lut_neuron_table #(
    .ADDR_W   (ADDR_W),
    .OUT_BITS (OUT_BITS)
  ) u_table (
    .clk         (clk),
    .i_sweep     (w_sweep),
    .i_sweepAddr (r_clrPtr),
    .i_cfgWe     (w_cfgWe),
    .i_cfgAddr   (cfg_addr),
    .i_cfgData   (cfg_data),
    .i_rdAddr    (in_data),
    .o_rdData    (w_rdData)
  );

  // A config write in the same cycle as cfg_clr still lands; the sweep then overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_CLEAR;
      r_clrPtr <= '0;
      r_busy   <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clrPtr <= r_clrPtr + 1'b1;
          if (r_clrPtr == LAST_PTR) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cfg_clr) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // A pending result may still drain while the sweep runs because out_ready is honoured in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_outData  <= w_rdData;
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cfg_busy   = r_busy;
  assign in_ready   = w_inReady;
  assign out_valid  = r_outValid;
  assign out_data   = r_outData;
  assign lookup_cnt = r_cnt;

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Self-checking bench for lut_neuron_prog with directed scenarios and a random phase.
// The reference keeps a plain table array, a sweep countdown and a queue-free output register.
module tb_lut_neuron_prog;
  import lut_neuron_pkg::*;

  localparam int FANIN    = 4;
  localparam int IN_BITS  = 2;
  localparam int OUT_BITS = 2;
  localparam int CNT_W    = 4;
  localparam int ADDR_W   = FANIN * IN_BITS;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                cfg_we = 1'b0;
  logic [ADDR_W-1:0]   cfg_addr = '0;
  logic [OUT_BITS-1:0] cfg_data = '0;
  logic                cfg_clr = 1'b0;
  logic                cfg_busy;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [OUT_BITS-1:0] out_data;
  logic [CNT_W-1:0]    lookup_cnt;

  lut_neuron_prog #(
    .FANIN    (FANIN),
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_clr    (cfg_clr),
    .cfg_busy   (cfg_busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .lookup_cnt (lookup_cnt)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  int mdlTable [DEPTH];
  int sweepLeft = 0;
  int expV = 0;
  int expD = 0;
  int expCnt = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic idleInputs();
    cfg_we   = 1'b0;
    cfg_clr  = 1'b0;
    in_valid = 1'b0;
  endtask

  // One clock: check every output against the reference, advance the reference, then step to the next negedge.
  task automatic applyStimulus();
    int rdyExp;
    int nextD;
    bit acc;
    #1;
    rdyExp = ((sweepLeft == 0) && (expV == 0 || out_ready)) ? 1 : 0;
    checkOutput("cfg_busy", int'(cfg_busy), (sweepLeft > 0) ? 1 : 0);
    checkOutput("in_ready", int'(in_ready), rdyExp);
    checkOutput("out_valid", int'(out_valid), expV);
    checkOutput("out_data", int'(out_data), expD);
    checkOutput("lookup_cnt", int'(lookup_cnt), expCnt);
    acc   = in_valid && (rdyExp == 1);
    nextD = mdlTable[int'(in_data)];
    if (sweepLeft > 0) begin
      sweepLeft--;
    end else begin
      if (cfg_we) mdlTable[int'(cfg_addr)] = int'(cfg_data);
      if (cfg_clr) begin
        sweepLeft = DEPTH;
        foreach (mdlTable[i]) mdlTable[i] = 0;
      end
    end
    if (acc) begin
      expV = 1;
      expD = nextD;
      if (expCnt < CNT_MAX) expCnt++;
    end else if (expV == 1 && out_ready) begin
      expV = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_lookup_cnt", int'(lookup_cnt), 0);
    checkOutput("rst_cfg_busy", int'(cfg_busy), 1);
    checkOutput("rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    sweepLeft = DEPTH;
    expV = 0;
    expD = 0;
    expCnt = 0;
    foreach (mdlTable[i]) mdlTable[i] = 0;
  endtask

  // Counts observed busy cycles with a hard bound so a stuck sweep still reaches the summary.
  task automatic waitSweep(input int expectedLen);
    int busyCycles = 0;
    int guard = 0;
    idleInputs();
    while (cfg_busy && guard < 4 * DEPTH) begin
      busyCycles++;
      guard++;
      applyStimulus();
    end
    checkOutput("sweep_len", busyCycles, expectedLen);
  endtask

  task automatic cfgWrite(input int addr, input int data);
    idleInputs();
    cfg_we   = 1'b1;
    cfg_addr = ADDR_W'(addr);
    cfg_data = OUT_BITS'(data);
    applyStimulus();
    cfg_we = 1'b0;
  endtask

  task automatic lookup(input int addr);
    in_valid = 1'b1;
    in_data  = ADDR_W'(addr);
    applyStimulus();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [MAX_ADDR_W-1:0] word;

    // Reset, then a lookup of a swept entry.
    doReset();
    waitSweep(DEPTH);
    out_ready = 1'b1;
    lookup('hA5);
    applyStimulus();
    doReset();
    waitSweep(DEPTH);

    // Program two entries and stream three back-to-back lookups.
    cfgWrite('h20, 2);
    cfgWrite('h31, 1);
    lookup('h20);
    lookup('h31);
    lookup('h00);
    applyStimulus();
    checkOutput("cnt_after_stream", int'(lookup_cnt), 3);

    // Backpressure: hold a 2'b10 result, keep offering a request, then release.
    out_ready = 1'b0;
    lookup('h20);
    in_valid = 1'b1;
    in_data  = 8'h31;
    for (int i = 0; i < 5; i++) applyStimulus();
    out_ready = 1'b1;
    applyStimulus();
    in_valid = 1'b0;
    applyStimulus();

    // Same-cycle lookup and write to one address returns the old contents.
    cfgWrite('h10, 1);
    cfg_we   = 1'b1;
    cfg_addr = 8'h10;
    cfg_data = 2'b11;
    lookup('h10);
    cfg_we = 1'b0;
    lookup('h10);
    applyStimulus();

    // Clear with a result pending; a write during the sweep must be dropped.
    out_ready = 1'b0;
    lookup('h20);
    cfg_clr = 1'b1;
    applyStimulus();
    cfg_clr = 1'b0;
    applyStimulus();
    out_ready = 1'b1;
    applyStimulus();
    cfg_we   = 1'b1;
    cfg_addr = 8'h31;
    cfg_data = 2'b11;
    applyStimulus();
    cfg_we = 1'b0;
    waitSweep(DEPTH - 3);
    for (int a = 0; a < DEPTH; a++) lookup(a);
    applyStimulus();
    checkOutput("cnt_saturated", int'(lookup_cnt), CNT_MAX);

    // Random traffic, occasional clears, channel-wise packed inputs.
    for (int n = 0; n < 1500; n++) begin
      word = '0;
      for (int c = 0; c < FANIN; c++) word = packChannel(word, c, IN_BITS, MAX_ADDR_W'($urandom_range(0, 3)));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = word[ADDR_W-1:0];
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
      cfg_data  = OUT_BITS'($urandom_range(0, 3));
      cfg_clr   = ($urandom_range(0, 499) == 0);
      applyStimulus();
    end
    idleInputs();
    out_ready = 1'b1;

    // Reset mid-sweep must restart a full sweep and clear the counter.
    cfg_clr = 1'b1;
    applyStimulus();
    cfg_clr = 1'b0;
    for (int i = 0; i < 50; i++) applyStimulus();
    doReset();
    waitSweep(DEPTH);
    lookup('h31);
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
